// File: rtl/sifive_handshake_monitor_pkg.sv
// Shared types and width helpers for the multi-channel valid/ready protocol checker.
package sifive_handshake_monitor_pkg;

  typedef enum logic [2:0] {
    ERR_NONE         = 3'd0,
    ERR_SEL_CONFLICT = 3'd1,
    ERR_VALID_DROP   = 3'd2,
    ERR_DATA_CHANGE  = 3'd3,
    ERR_TIMEOUT      = 3'd4,
    ERR_OVERFLOW     = 3'd5,
    ERR_UNDERFLOW    = 3'd6
  } err_code_t;

  // Bit k of this struct carries error code k+1, so priority is simply LSB first.
  typedef struct packed {
    logic timeout;
    logic data_change;
    logic valid_drop;
    logic sel_conflict;
  } ch_err_t;

  function automatic int ch_idx_w(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

  function automatic int outst_w(input int max_outst, input int n_ch);
    return $clog2(max_outst + n_ch + 1);
  endfunction

endpackage

// File: rtl/sifive_handshake_monitor_ch.sv
// Per-channel checker: stall FSM, captured payload/select, stall watchdog and error vector.
module sifive_handshake_monitor_ch
  import sifive_handshake_monitor_pkg::*;
#(
  parameter int W_DATA  = 32,
  parameter int W_SEL   = 3,
  parameter int TIMEOUT = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid,
  input  logic              ready,
  input  logic [W_DATA-1:0] data,
  input  logic [W_SEL-1:0]  sel,
  output ch_err_t           err
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] STALL = 1'b1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  logic [0:0]        state;
  logic [W_DATA-1:0] cap_data;
  logic [W_SEL-1:0]  cap_sel;
  logic [CW-1:0]     cnt;

  logic stalled, in_stall;
  assign stalled  = valid & ~ready;
  assign in_stall = (state == STALL);

  always_comb begin
    err = '0;
    if (!reset) begin
      err.sel_conflict = valid && ($countones(sel) > 1);
      err.valid_drop   = in_stall && !valid;
      err.data_change  = in_stall && stalled && ({data, sel} != {cap_data, cap_sel});
      // Counter saturates at TIMEOUT, so this compare can only match once per episode.
      err.timeout      = in_stall && stalled && (cnt == TO_LAST);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      cap_data <= '0;
      cap_sel  <= '0;
    end else if (!in_stall) begin
      if (stalled) begin
        state    <= STALL;
        cap_data <= data;
        cap_sel  <= sel;
        cnt      <= CW'(1);
      end
    end else if (!valid || ready) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      cap_data <= data;
      cap_sel  <= sel;
      if (cnt != TO_MAX) cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/sifive_handshake_monitor.sv
// Multi-channel handshake checker: per-channel monitors, outstanding-request bound,
// priority-encoded registered error report and sticky flags.
module sifive_handshake_monitor
  import sifive_handshake_monitor_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int W_DATA    = 32,
  parameter int W_SEL     = 3,
  parameter int TIMEOUT   = 1024,
  parameter int MAX_OUTST = 8,
  parameter int FATAL_EN  = 1,
  localparam int CH_W  = ch_idx_w(N_CH),
  localparam int OUT_W = outst_w(MAX_OUTST, N_CH)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_CH-1:0]          in_valid,
  input  logic [N_CH-1:0]          in_ready,
  input  logic [N_CH*W_DATA-1:0]   in_data,
  input  logic [N_CH*W_SEL-1:0]    in_sel,
  input  logic                     rsp_fire,
  input  logic                     clear_sticky,
  output logic                     err_valid,
  output logic [2:0]               err_code,
  output logic [CH_W-1:0]          err_ch,
  output logic                     err_multi,
  output logic [N_CH:0]            err_sticky,
  output logic [OUT_W-1:0]         outst_count
);

  localparam logic [OUT_W:0] MAX_V = (OUT_W+1)'(MAX_OUTST);
  localparam logic [OUT_W:0] CAP_V = (OUT_W+1)'(MAX_OUTST + N_CH);

  ch_err_t [N_CH-1:0] ch_err;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    sifive_handshake_monitor_ch #(
      .W_DATA (W_DATA),
      .W_SEL  (W_SEL),
      .TIMEOUT(TIMEOUT)
    ) u_ch (
      .clock(clock),
      .reset(reset),
      .valid(in_valid[g]),
      .ready(in_ready[g]),
      .data (in_data[g*W_DATA +: W_DATA]),
      .sel  (in_sel[g*W_SEL +: W_SEL]),
      .err  (ch_err[g])
    );
  end

  logic [OUT_W:0]   sum, nxt;
  logic [OUT_W-1:0] outst_next;
  logic             ovf, udf;

  always_comb begin
    sum        = {1'b0, outst_count} + (OUT_W+1)'($countones(in_valid & in_ready));
    nxt        = sum - (OUT_W+1)'(rsp_fire);
    ovf        = 1'b0;
    udf        = 1'b0;
    outst_next = nxt[OUT_W-1:0];
    if (rsp_fire && sum == '0) begin
      udf        = 1'b1;
      outst_next = '0;
    end else begin
      ovf = (nxt > MAX_V);
      // Repeated overflow could otherwise outgrow the register; pin at the worst single-step value.
      if (nxt > CAP_V) outst_next = CAP_V[OUT_W-1:0];
    end
    if (reset) begin
      ovf = 1'b0;
      udf = 1'b0;
    end
  end

  err_code_t       rpt_code;
  logic [CH_W-1:0] rpt_ch;
  logic            found;
  logic [N_CH:0]   new_sticky;

  always_comb begin
    rpt_code   = ERR_NONE;
    rpt_ch     = '0;
    found      = 1'b0;
    new_sticky = '0;
    for (int i = 0; i < N_CH; i++) begin
      new_sticky[i] = |ch_err[i];
      for (int c = 0; c < 4; c++) begin
        if (!found && ch_err[i][c]) begin
          found    = 1'b1;
          rpt_code = err_code_t'(3'(c + 1));
          rpt_ch   = CH_W'(i);
        end
      end
    end
    new_sticky[N_CH] = ovf | udf;
    if (!found && ovf) begin
      found    = 1'b1;
      rpt_code = ERR_OVERFLOW;
    end else if (!found && udf) begin
      found    = 1'b1;
      rpt_code = ERR_UNDERFLOW;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      err_valid   <= 1'b0;
      err_code    <= 3'd0;
      err_ch      <= '0;
      err_multi   <= 1'b0;
      err_sticky  <= '0;
      outst_count <= '0;
    end else begin
      err_valid   <= found;
      err_code    <= rpt_code;
      err_ch      <= rpt_ch;
      err_multi   <= ($countones({ch_err, ovf, udf}) > 1);
      err_sticky  <= clear_sticky ? new_sticky : (err_sticky | new_sticky);
      outst_count <= outst_next;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clock) begin
    if (FATAL_EN != 0 && err_valid)
      $fatal(1, "handshake monitor: error code %0d on channel %0d", err_code, err_ch);
  end
`endif

endmodule

// File: tb/tb_sifive_handshake_monitor.sv
// Randomized + directed bench; a history-based reference model feeds a per-cycle scoreboard.
module tb_sifive_handshake_monitor;
  localparam int N = 4, WD = 32, WS = 3, TO = 1024, MO = 8;
  localparam int CW = 2, OW = 4;

  logic clock = 1'b0;
  logic reset, rsp_fire, clear_sticky;
  logic [N-1:0] in_valid, in_ready;
  logic [N*WD-1:0] in_data;
  logic [N*WS-1:0] in_sel;
  logic err_valid, err_multi;
  logic [2:0] err_code;
  logic [CW-1:0] err_ch;
  logic [N:0] err_sticky;
  logic [OW-1:0] outst_count;

  always #5 clock = ~clock;

  sifive_handshake_monitor #(
    .N_CH(N), .W_DATA(WD), .W_SEL(WS), .TIMEOUT(TO), .MAX_OUTST(MO), .FATAL_EN(0)
  ) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .rsp_fire(rsp_fire), .clear_sticky(clear_sticky),
    .err_valid(err_valid), .err_code(err_code), .err_ch(err_ch), .err_multi(err_multi),
    .err_sticky(err_sticky), .outst_count(outst_count)
  );

  typedef struct packed {
    logic ev; logic [2:0] code; logic [CW-1:0] ch; logic multi;
    logic [N:0] sticky; logic [OW-1:0] outst;
  } exp_t;

  exp_t q[$];
  int tests = 0, fails = 0;

  // stimulus for the next cycle
  logic nrst, nclr, nrsp;
  logic [N-1:0] nv, nr;
  logic [WD-1:0] nd[N];
  logic [WS-1:0] ns[N];

  // reference model: stall run lengths and previous samples
  int run[N];
  bit stl[N];
  logic [WD-1:0] pd[N];
  logic [WS-1:0] ps[N];
  int mcnt = 0;
  logic [N:0] msticky = '0;

  task automatic model();
    exp_t e;
    int ech[$], ecode[$];
    int fires;
    logic v, r;
    logic [WD-1:0] d;
    logic [WS-1:0] s;
    logic [N:0] nw;
    e = '0;
    if (reset) begin
      for (int i = 0; i < N; i++) begin run[i] = 0; stl[i] = 0; end
      mcnt = 0; msticky = '0;
      q.push_back(e);
      return;
    end
    for (int i = 0; i < N; i++) begin
      v = in_valid[i]; r = in_ready[i];
      d = in_data[i*WD +: WD]; s = in_sel[i*WS +: WS];
      if (v && $countones(s) > 1) begin ech.push_back(i); ecode.push_back(1); end
      if (stl[i] && !v) begin ech.push_back(i); ecode.push_back(2); end
      else if (stl[i] && !r && (d != pd[i] || s != ps[i])) begin ech.push_back(i); ecode.push_back(3); end
      run[i] = (v && !r) ? run[i] + 1 : 0;
      if (run[i] == TO) begin ech.push_back(i); ecode.push_back(4); end
      stl[i] = v && !r; pd[i] = d; ps[i] = s;
    end
    fires = $countones(in_valid & in_ready);
    if (rsp_fire && mcnt + fires == 0) begin
      ech.push_back(N); ecode.push_back(6);
    end else begin
      mcnt = mcnt + fires - int'(rsp_fire);
      if (mcnt > MO) begin ech.push_back(N); ecode.push_back(5); end
    end
    nw = '0;
    foreach (ech[k]) nw[ech[k]] = 1'b1;
    msticky = clear_sticky ? nw : (msticky | nw);
    if (ech.size() > 0) begin
      e.ev = 1'b1;
      e.code = 3'(ecode[0]);
      e.ch = (ech[0] == N) ? '0 : CW'(ech[0]);
      e.multi = ech.size() > 1;
    end
    e.sticky = msticky;
    e.outst = OW'(mcnt);
    q.push_back(e);
  endtask

  task automatic cyc();
    @(negedge clock);
    reset = nrst; clear_sticky = nclr; rsp_fire = nrsp;
    in_valid = nv; in_ready = nr;
    for (int i = 0; i < N; i++) begin
      in_data[i*WD +: WD] = nd[i];
      in_sel[i*WS +: WS] = ns[i];
    end
    model();
  endtask

  task automatic idle();
    nrst = 0; nclr = 0; nrsp = 0; nv = '0; nr = '0;
    for (int i = 0; i < N; i++) ns[i] = '0;
  endtask

  task automatic rand_step();
    int k;
    idle();
    nrst = ($urandom_range(0, 199) == 0);
    nclr = ($urandom_range(0, 31) == 0);
    nrsp = ($urandom_range(0, 2) == 0);
    for (int i = 0; i < N; i++) begin
      nv[i] = ($urandom_range(0, 3) != 0);
      nr[i] = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) nd[i] = $urandom;
      k = $urandom_range(0, 15);
      if (k == 0) ns[i] = 3'b110;
      else if (k < 4) ns[i] = 3'(1 << $urandom_range(0, 2));
      else if (k == 4) ns[i] = 3'b000;
      else ns[i] = ps[i];
    end
    // keep the outstanding count inside its representable range
    if (mcnt >= 6) begin nr = '0; nrsp = 1; end
  endtask

  // scoreboard monitor: one expected entry per clock edge
  always @(posedge clock) begin
    exp_t e, a;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = {err_valid, err_code, err_ch, err_multi, err_sticky, outst_count};
      tests++;
      if (a !== e) begin
        fails++;
        if (fails <= 20)
          $display("FAIL report @%0t: got v=%0d code=%0d ch=%0d multi=%0d sticky=%b outst=%0d, want v=%0d code=%0d ch=%0d multi=%0d sticky=%b outst=%0d",
                   $time, a.ev, a.code, a.ch, a.multi, a.sticky, a.outst,
                   e.ev, e.code, e.ch, e.multi, e.sticky, e.outst);
      end
    end
  end

  initial begin
    reset = 1; clear_sticky = 0; rsp_fire = 0;
    in_valid = '0; in_ready = '0; in_data = '0; in_sel = '0;
    for (int i = 0; i < N; i++) nd[i] = '0;
    idle();
    nrst = 1; repeat (3) cyc();
    nrst = 0;

    // data change on ch2 after three stalled cycles
    nv[2] = 1; nd[2] = 32'h1234; ns[2] = 3'b001;
    repeat (3) cyc();
    nd[2] = 32'h1235; cyc();
    nr[2] = 1; cyc();
    idle(); cyc();

    // single watchdog report, nothing again at 2048
    nv[0] = 1; nd[0] = 32'hA5A5_0000;
    repeat (2050) cyc();
    nr[0] = 1; cyc();
    idle(); cyc();

    // valid drop on ch1 with a select conflict on ch3 in the same cycle
    nv[1] = 1; nd[1] = 32'h7;
    repeat (2) cyc();
    nv[1] = 0; nv[3] = 1; nr[3] = 1; ns[3] = 3'b011; cyc();
    idle(); cyc();

    // outstanding overflow then underflow
    nrst = 1; cyc(); nrst = 0;
    nv[0] = 1; nr[0] = 1;
    repeat (9) cyc();
    idle(); nrsp = 1;
    repeat (10) cyc();
    idle(); cyc();

    // reset in the middle of a stall restarts the watchdog
    nv[0] = 1; nd[0] = 32'h5;
    repeat (500) cyc();
    nrst = 1; repeat (2) cyc();
    nrst = 0; repeat (1030) cyc();
    nr[0] = 1; cyc();
    idle(); cyc();

    // clear_sticky loses to a same-cycle ch0 error
    nv[1] = 1; nr[1] = 1; ns[1] = 3'b110; cyc();
    idle(); cyc();
    nclr = 1; nv[0] = 1; nr[0] = 1; ns[0] = 3'b101; cyc();
    idle(); cyc(); cyc();

    repeat (1500) begin rand_step(); cyc(); end

    idle(); cyc(); cyc();
    repeat (2) @(posedge clock);
    #2;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected entries left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
